// File: rtl/vliw_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vliw_pipe_pkg
// Description : Shared defaults, lane-slice helper and entry record for the
//               VLIW bundle pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vliw_pipe_pkg;

    localparam int c_LANES  = 2;
    localparam int c_DATA_W = 32;
    localparam int c_CTRL_W = 8;
    localparam int c_CNT_W  = 16;

    // Low bit of lane 'lane' inside a flat vector of 'width'-bit lane slices.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    typedef struct packed {
        logic                         valid;
        logic [c_LANES-1:0]           lane_valid;
        logic [c_LANES*c_DATA_W-1:0]  data;
        logic [c_LANES*c_CTRL_W-1:0]  ctrl;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/vliw_pipe_entry.sv
`default_nettype none
// ============================================================================
// Module      : vliw_pipe_entry
// Description : One bundle storage entry with load (kill applied), drop and
//               flush-clear; clear has priority over load over drop.
// Revision    : 1.0 - initial release
// ============================================================================
module vliw_pipe_entry
    import vliw_pipe_pkg::*;
#(
    parameter int LANES  = c_LANES,
    parameter int DATA_W = c_DATA_W,
    parameter int CTRL_W = c_CTRL_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_load,
    input  logic                       i_drop,
    input  logic [LANES-1:0]           i_kill,
    input  logic [LANES*DATA_W-1:0]    i_data,
    input  logic [LANES*CTRL_W-1:0]    i_ctrl,
    output logic                       o_valid,
    output logic [LANES-1:0]           o_lane_valid,
    output logic [LANES*DATA_W-1:0]    o_data,
    output logic [LANES*CTRL_W-1:0]    o_ctrl
);

    logic                    r_valid;
    logic [LANES-1:0]        r_lane_valid;
    logic [LANES*DATA_W-1:0] r_data;
    logic [LANES*CTRL_W-1:0] r_ctrl;
    logic [LANES*CTRL_W-1:0] w_ctrl_masked;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_ctrl_masked[lane_lo(g, CTRL_W) +: CTRL_W] =
            i_kill[g] ? '0 : i_ctrl[lane_lo(g, CTRL_W) +: CTRL_W];
    end

    // Data is left untouched by clear; only the valid/ctrl view must vanish.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_lane_valid <= '0;
            r_data       <= '0;
            r_ctrl       <= '0;
        end else if (i_clear) begin
            r_valid      <= 1'b0;
            r_lane_valid <= '0;
            r_ctrl       <= '0;
        end else if (i_load) begin
            r_valid      <= 1'b1;
            r_lane_valid <= ~i_kill;
            r_data       <= i_data;
            r_ctrl       <= w_ctrl_masked;
        end else if (i_drop) begin
            r_valid      <= 1'b0;
            r_lane_valid <= '0;
        end
    end

    assign o_valid      = r_valid;
    assign o_lane_valid = r_lane_valid;
    assign o_data       = r_data;
    assign o_ctrl       = r_ctrl;

endmodule
`default_nettype wire

// File: rtl/vliw_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : vliw_pipe_stage
// Description : Elastic valid/ready stage for a multi-lane VLIW bundle with
//               flush, per-lane kill and a saturating stall counter.
//               VLIW_PIPE_SKID_EN selects the registered-ready 2-entry skid
//               variant; otherwise a single entry with combinational ready.
// Revision    : 1.0 - initial release
// ============================================================================
module vliw_pipe_stage
    import vliw_pipe_pkg::*;
#(
    parameter int LANES  = c_LANES,
    parameter int DATA_W = c_DATA_W,
    parameter int CTRL_W = c_CTRL_W,
    parameter int CNT_W  = c_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0]           in_kill,
    input  logic [LANES*DATA_W-1:0]    in_data,
    input  logic [LANES*CTRL_W-1:0]    in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           out_lane_valid,
    output logic [LANES*DATA_W-1:0]    out_data,
    output logic [LANES*CTRL_W-1:0]    out_ctrl,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic                    w_accept;
    logic                    w_consume;
    logic                    w_main_load;
    logic                    w_main_drop;
    logic [LANES-1:0]        w_main_kill;
    logic [LANES*DATA_W-1:0] w_main_data;
    logic [LANES*CTRL_W-1:0] w_main_ctrl;
    logic                    w_main_valid;
    logic [CNT_W-1:0]        r_stall_cnt;

    assign w_accept  = in_valid & in_ready;
    assign w_consume = w_main_valid & out_ready;

`ifdef VLIW_PIPE_SKID_EN
    logic                    w_skid_load;
    logic                    w_skid_drop;
    logic                    w_skid_valid;
    logic [LANES-1:0]        w_skid_lane_valid;
    logic [LANES*DATA_W-1:0] w_skid_data;
    logic [LANES*CTRL_W-1:0] w_skid_ctrl;

    // Skid only fills when main is held; it drains into main on consume.
    assign w_skid_load = w_accept & w_main_valid & ~w_consume;
    assign w_skid_drop = w_consume & w_skid_valid;
    assign w_main_load = (w_accept & (~w_main_valid | w_consume)) |
                         (w_skid_valid & w_consume);
    assign w_main_drop = w_consume;

    // Skid contents were already kill-masked at capture, so re-masking is a no-op.
    assign w_main_kill = w_skid_valid ? ~w_skid_lane_valid : in_kill;
    assign w_main_data = w_skid_valid ? w_skid_data : in_data;
    assign w_main_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;

    assign in_ready = ~w_skid_valid;

    vliw_pipe_entry #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (flush),
        .i_load       (w_skid_load),
        .i_drop       (w_skid_drop),
        .i_kill       (in_kill),
        .i_data       (in_data),
        .i_ctrl       (in_ctrl),
        .o_valid      (w_skid_valid),
        .o_lane_valid (w_skid_lane_valid),
        .o_data       (w_skid_data),
        .o_ctrl       (w_skid_ctrl)
    );
`else
    assign w_main_load = w_accept;
    assign w_main_drop = w_consume;
    assign w_main_kill = in_kill;
    assign w_main_data = in_data;
    assign w_main_ctrl = in_ctrl;

    assign in_ready = ~w_main_valid | out_ready;
`endif

    vliw_pipe_entry #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (flush),
        .i_load       (w_main_load),
        .i_drop       (w_main_drop),
        .i_kill       (w_main_kill),
        .i_data       (w_main_data),
        .i_ctrl       (w_main_ctrl),
        .o_valid      (w_main_valid),
        .o_lane_valid (out_lane_valid),
        .o_data       (out_data),
        .o_ctrl       (out_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !out_ready && r_stall_cnt != c_CNT_MAX) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid = w_main_valid;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vliw_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_vliw_pipe_stage
// Description : Directed, table-driven bench for vliw_pipe_stage (2 lanes,
//               32-bit data, 8-bit ctrl, 4-bit stall counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vliw_pipe_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kill;
    logic [63:0] in_data;
    logic [15:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_lane_valid;
    logic [63:0] out_data;
    logic [15:0] out_ctrl;
    logic [3:0]  stall_cnt;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        in_valid;
        logic [1:0]  kill;
        logic [63:0] data;
        logic [15:0] ctrl;
        logic        out_ready;
        logic        exp_valid;
        logic        chk_payload;
        logic [1:0]  exp_lv;
        logic [63:0] exp_data;
        logic [15:0] exp_ctrl;
    } vec_t;

    localparam int c_NVEC = 12;
    vec_t vecs[c_NVEC];

    localparam logic [63:0] c_A = 64'h0000_00A1_0000_00A0;
    localparam logic [63:0] c_B = 64'h0000_00B1_0000_00B0;
    localparam logic [63:0] c_C = 64'h0000_00C1_0000_00C0;
    localparam logic [63:0] c_D = 64'h0000_00D1_0000_00D0;
    localparam logic [63:0] c_E = 64'h0000_00E1_0000_00E0;
    localparam logic [63:0] c_F = 64'h0000_00F1_0000_00F0;
    localparam logic [63:0] c_G = 64'h0000_0071_0000_0070;

`ifdef VLIW_PIPE_SKID_EN
    localparam logic [63:0] c_STALL_AFTER_FLUSH = 64'd6;
`else
    localparam logic [63:0] c_STALL_AFTER_FLUSH = 64'd5;
`endif

    vliw_pipe_stage #(
        .LANES  (2),
        .DATA_W (32),
        .CTRL_W (8),
        .CNT_W  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_kill        (in_kill),
        .in_data        (in_data),
        .in_ctrl        (in_ctrl),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .out_data       (out_data),
        .out_ctrl       (out_ctrl),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected summary before 200us");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] k, input logic [63:0] d,
                                input logic [15:0] c, input logic ev, input logic cp,
                                input logic [1:0] elv, input logic [63:0] ed,
                                input logic [15:0] ec);
        vec_t r;
        r.in_valid = v;   r.kill = k;        r.data = d;       r.ctrl = c;
        r.out_ready = 1'b1;
        r.exp_valid = ev; r.chk_payload = cp; r.exp_lv = elv;
        r.exp_data = ed;  r.exp_ctrl = ec;
        return r;
    endfunction

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_kill = '0;
        in_data = '0;
        in_ctrl = '0;
        out_ready = 1'b0;

        // Streaming: lane0 0x10+k, lane1 0x20+k, one bundle per cycle.
        for (int k = 0; k < 8; k++) begin
            logic [63:0] d;
            logic [15:0] c;
            d = {32'h20 + 32'(k), 32'h10 + 32'(k)};
            c = {8'hB0 + 8'(k), 8'hA0 + 8'(k)};
            vecs[k] = mk(1'b1, 2'b00, d, c, 1'b1, 1'b1, 2'b11, d, c);
        end
        vecs[8]  = mk(1'b1, 2'b10, 64'hDEAD_BEEF_1234_5678, 16'hFFFF,
                      1'b1, 1'b1, 2'b01, 64'hDEAD_BEEF_1234_5678, 16'h00FF);
        vecs[9]  = mk(1'b1, 2'b11, 64'h0000_0001_0000_0002, 16'h5A5A,
                      1'b1, 1'b1, 2'b00, 64'h0000_0001_0000_0002, 16'h0000);
        vecs[10] = mk(1'b1, 2'b01, 64'hCAFE_F00D_0BAD_BEEF, 16'h3C3C,
                      1'b1, 1'b1, 2'b10, 64'hCAFE_F00D_0BAD_BEEF, 16'h3C00);
        vecs[11] = mk(1'b0, 2'b00, 64'h0, 16'h0, 1'b0, 1'b0, 2'b00, 64'h0, 16'h0);

        // Reset state
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_lane_valid", 64'(out_lane_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_out_valid", 64'(out_valid), 64'd0);
            check("idle_in_ready", 64'(in_ready), 64'd1);
            check("idle_stall", 64'(stall_cnt), 64'd0);
        end

        // Table: streaming, kill patterns, drain
        for (int i = 0; i < c_NVEC; i++) begin
            in_valid  = vecs[i].in_valid;
            in_kill   = vecs[i].kill;
            in_data   = vecs[i].data;
            in_ctrl   = vecs[i].ctrl;
            out_ready = vecs[i].out_ready;
            step();
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
            if (vecs[i].chk_payload) begin
                check($sformatf("vec%0d_lane_valid", i), 64'(out_lane_valid), 64'(vecs[i].exp_lv));
                check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
                check($sformatf("vec%0d_ctrl", i), 64'(out_ctrl), 64'(vecs[i].exp_ctrl));
            end
        end
        in_kill = '0;
        in_ctrl = 16'h0101;

        // Back-pressure: A held, B/C wait, then drain in order A, B, C
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = c_A;
        step();
        check("bp_first_A", out_data, c_A);
`ifdef VLIW_PIPE_SKID_EN
        check("bp_ready_after_A", 64'(in_ready), 64'd1);
        in_data = c_B;
        step();
        check("bp_skid_full_ready", 64'(in_ready), 64'd0);
        check("bp_hold_A", out_data, c_A);
        in_data = c_C;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_A", out_data, c_A);
            check("bp_ready_low", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_order_B", out_data, c_B);
        check("bp_ready_rise", 64'(in_ready), 64'd1);
`else
        check("bp_ready_after_A", 64'(in_ready), 64'd0);
        in_data = c_B;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_A", out_data, c_A);
            check("bp_ready_low", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_comb_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_order_B", out_data, c_B);
        in_data = c_C;
`endif
        step();
        check("bp_order_C", out_data, c_C);
        check("bp_C_valid", 64'(out_valid), 64'd1);
        check("bp_stall_cnt", 64'(stall_cnt), 64'd4);
        in_valid = 1'b0;
        step();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Flush of a full stage with a simultaneous incoming bundle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = c_D;
        in_ctrl   = 16'h7777;
        step();
`ifdef VLIW_PIPE_SKID_EN
        in_data = c_E;
        step();
        check("fl_full_ready", 64'(in_ready), 64'd0);
`endif
        in_data = c_F;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_lane_valid", 64'(out_lane_valid), 64'd0);
        check("fl_out_ctrl", 64'(out_ctrl), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_no_ghost", 64'(out_valid), 64'd0);
        end
        check("fl_stall_kept", 64'(stall_cnt), c_STALL_AFTER_FLUSH);

        // Saturation, then asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = c_G;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("sat_stall", 64'(stall_cnt), 64'd15);
        check("sat_held_G", out_data, c_G);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_lane_valid", 64'(out_lane_valid), 64'd0);
        check("arst_out_data", out_data, 64'd0);
        check("arst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("arst_stall", 64'(stall_cnt), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        step();
        reset = 1'b0;
        step();
        check("post_rst_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
